// File: rtl/clkgen_pkg.sv
// Shared types and command constants for the DCM_CLKGEN runtime M/D programmer.
package clkgen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_D,
    GAP1,
    LOAD_M,
    GAP2,
    GO,
    WAIT_DONE,
    FINISH
  } state_e;

  // Command headers, sent header[1] first.
  localparam logic [1:0]  CMD_LOADD = 2'b10;
  localparam logic [1:0]  CMD_LOADM = 2'b11;
  localparam logic        CMD_GO    = 1'b0;
  localparam int unsigned CMD_LEN   = 10;

endpackage

// File: rtl/clkgen_prog_ser.sv
// 10-bit load/shift serializer for LoadD/LoadM commands; shifts in zeros so
// bit_o idles low between commands.
module clkgen_prog_ser
  import clkgen_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [1:0] header_i,
  input  logic [7:0] data_i,
  output logic       bit_o,
  output logic       last_o
);

  localparam logic [3:0] LAST_IDX = 4'(CMD_LEN - 1);

  logic [CMD_LEN-1:0] sreg_q, sreg_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               active_q, active_d;

  always_comb begin
    sreg_d   = {1'b0, sreg_q[CMD_LEN-1:1]};
    cnt_d    = cnt_q;
    active_d = active_q;
    if (load_i) begin
      sreg_d   = {data_i, header_i[0], header_i[1]};
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == LAST_IDX) begin
        active_d = 1'b0;
        cnt_d    = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign bit_o  = sreg_q[0];
  assign last_o = active_q && (cnt_q == LAST_IDX);

endmodule

// File: rtl/clkgen_prog.sv
// DCM_CLKGEN runtime M/D reprogramming controller: start/busy handshake in,
// LoadD / LoadM / GO serialized onto PROGEN/PROGDATA, then wait for PROGDONE+LOCKED.
module clkgen_prog
  import clkgen_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] m_minus1,
  input  logic [7:0] d_minus1,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       progen,
  output logic       progdata,
  input  logic       progdone,
  input  logic       locked
);

  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [7:0]      m_q, m_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [TW-1:0]   to_q, to_d;
  logic            progen_q, progen_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            ser_load;
  logic [1:0]      ser_hdr;
  logic [7:0]      ser_data;
  logic            ser_bit;
  logic            ser_last;

  clkgen_prog_ser u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (ser_load),
    .header_i (ser_hdr),
    .data_i   (ser_data),
    .bit_o    (ser_bit),
    .last_o   (ser_last)
  );

  // D goes straight into the serializer on accept; only M needs a holding register.
  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    gap_d    = '0;
    to_d     = '0;
    err_d    = 1'b0;
    ser_load = 1'b0;
    ser_hdr  = CMD_LOADD;
    ser_data = d_minus1;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (m_minus1 != '0) begin
            m_d      = m_minus1;
            ser_load = 1'b1;
            state_d  = LOAD_D;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD_D: begin
        if (ser_last) state_d = GAP1;
      end
      GAP1: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          gap_d    = '0;
          ser_load = 1'b1;
          ser_hdr  = CMD_LOADM;
          ser_data = m_q;
          state_d  = LOAD_M;
        end
      end
      LOAD_M: begin
        if (ser_last) state_d = GAP2;
      end
      GAP2: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = GO;
        end
      end
      GO: state_d = WAIT_DONE;
      WAIT_DONE: begin
        to_d = to_q + 1'b1;
        if ((to_q != '0) && progdone && locked) begin
          state_d = FINISH;
        end else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    progen_d = (state_d == LOAD_D) || (state_d == LOAD_M) || (state_d == GO);
    busy_d   = (state_d != IDLE) && (state_d != FINISH);
    done_d   = (state_d == FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      m_q      <= '0;
      gap_q    <= '0;
      to_q     <= '0;
      progen_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      gap_q    <= gap_d;
      to_q     <= to_d;
      progen_q <= progen_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign progen   = progen_q;
  assign progdata = ser_bit;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
